// File: rtl/mul_div_unit_pkg.sv
// Shared core constants for the multiply/divide unit and decode stage.
// Holds op encodings, FSM state encoding and default widths.
package mul_div_unit_pkg;

  localparam int DEF_WIDTH      = 16;
  localparam int DEF_REG_ADDR_W = 3;

  localparam logic [1:0] OP_MULL = 2'b00;
  localparam logic [1:0] OP_MULH = 2'b01;
  localparam logic [1:0] OP_DIV  = 2'b10;
  localparam logic [1:0] OP_MOD  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/mul_div_unit_if.sv
// Request/write-back bundle of the multiply/divide unit.
// master: start/op/a_in/b_in/dest out; slave: busy/done/wb*/divZero out.
interface mul_div_unit_if #(
  parameter int WIDTH      = 16,
  parameter int REG_ADDR_W = 3
) ();

  logic                  start;
  logic [1:0]            op;
  logic [WIDTH-1:0]      a_in;
  logic [WIDTH-1:0]      b_in;
  logic [REG_ADDR_W-1:0] dest;
  logic                  busy;
  logic                  done;
  logic                  wbEnable;
  logic [REG_ADDR_W-1:0] wbReg;
  logic [WIDTH-1:0]      wbData;
  logic                  divZero;

  modport master (
    output start, op, a_in, b_in, dest,
    input  busy, done, wbEnable, wbReg, wbData, divZero
  );

  modport slave (
    input  start, op, a_in, b_in, dest,
    output busy, done, wbEnable, wbReg, wbData, divZero
  );

endinterface

// File: rtl/mul_div_unit.sv
// Iterative unsigned mul/div unit: shift-add multiply, restoring divide.
// Ports: clock, reset (async high), bus (slave: request in, write-back out).
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int REG_ADDR_W = DEF_REG_ADDR_W
) (
  input  logic            clock,
  input  logic            reset,
  mul_div_unit_if.slave   bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t state, state_n;

  logic [CW-1:0]         cnt;
  logic [1:0]            op_q;
  logic [REG_ADDR_W-1:0] dest_q;
  logic [WIDTH-1:0]      opnd;
  logic [WIDTH-1:0]      hi;
  logic [WIDTH-1:0]      lo;

  logic                  accept;
  logic                  is_div;
  logic [WIDTH:0]        x;
  logic [WIDTH:0]        y;
  logic [WIDTH+1:0]      sum;
  logic                  neg;
  logic                  fin;
  logic [WIDTH-1:0]      res;

  assign accept = (state == ST_IDLE) && bus.start;
  assign is_div = op_q[1];
  assign fin    = (state == ST_DONE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      ST_IDLE: if (bus.start) state_n = ST_RUN;
      ST_RUN:  if (cnt == LAST) state_n = ST_DONE;
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // One adder/subtractor shared by both algorithms.
  // Divide: x is the partial remainder shifted left with the next
  // dividend bit; the extra top bit of sum is the borrow.
  always_comb begin
    if (is_div) begin
      x   = {hi, lo[WIDTH-1]};
      y   = {1'b0, opnd};
      sum = {1'b0, x} - {1'b0, y};
    end else begin
      x   = {1'b0, hi};
      y   = {1'b0, lo[0] ? opnd : '0};
      sum = {1'b0, x} + {1'b0, y};
    end
  end

  assign neg = sum[WIDTH+1];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      op_q   <= OP_MULL;
      dest_q <= '0;
      opnd   <= '0;
      hi     <= '0;
      lo     <= '0;
    end else if (accept) begin
      cnt    <= '0;
      op_q   <= bus.op;
      dest_q <= bus.dest;
      hi     <= '0;
      // lo holds the multiplier (mul) or the dividend/quotient (div).
      if (bus.op[1]) begin
        lo   <= bus.a_in;
        opnd <= bus.b_in;
      end else begin
        lo   <= bus.b_in;
        opnd <= bus.a_in;
      end
    end else if (state == ST_RUN) begin
      cnt <= cnt + 1'b1;
      if (is_div) begin
        // Remainder stays below the divisor, so the top bit is zero.
        if (neg) hi <= x[WIDTH-1:0];
        else     hi <= sum[WIDTH-1:0];
        lo <= {lo[WIDTH-2:0], ~neg};
      end else begin
        hi <= sum[WIDTH:1];
        lo <= {sum[0], lo[WIDTH-1:1]};
      end
    end
  end

  always_comb begin
    res = '0;
    unique case (op_q)
      OP_MULL: res = lo;
      OP_MULH: res = hi;
      OP_DIV:  res = lo;
      OP_MOD:  res = hi;
      default: res = '0;
    endcase
  end

  // Zero outside DONE so the write-back mux can OR sources.
  assign bus.busy     = (state != ST_IDLE);
  assign bus.done     = fin;
  assign bus.wbEnable = fin;
  assign bus.wbReg    = fin ? dest_q : '0;
  assign bus.wbData   = fin ? res : '0;
  assign bus.divZero  = fin && is_div && (opnd == '0);

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed and random ops
// compared against a plain-arithmetic reference model.
module tb_mul_div_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   wb_count = 0;

  always #5 clk = ~clk;

  mul_div_unit_if bus ();

  mul_div_unit dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  always @(posedge clk) if (bus.wbEnable === 1'b1) wb_count++;

  function automatic logic [15:0] ref_res(input logic [1:0] o,
                                          input logic [15:0] a,
                                          input logic [15:0] b);
    logic [31:0] p;
    p = 32'(a) * 32'(b);
    case (o)
      2'd0: return p[15:0];
      2'd1: return p[31:16];
      2'd2: return (b == 0) ? 16'hFFFF : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, 32'(bus.busy), 0);
    check({tag, "_done"}, 32'(bus.done), 0);
    check({tag, "_wben"}, 32'(bus.wbEnable), 0);
    check({tag, "_wbreg"}, 32'(bus.wbReg), 0);
    check({tag, "_wbdata"}, 32'(bus.wbData), 0);
    check({tag, "_dz"}, 32'(bus.divZero), 0);
  endtask

  // Issue one op and check latency, busy, and the write-back cycle.
  // Inputs are scrambled after acceptance; results must not change.
  task automatic run_op(input string tag, input logic [1:0] o,
                        input logic [15:0] a, input logic [15:0] b,
                        input logic [2:0] d);
    logic [15:0] exp;
    int lat;
    bit busy_ok;
    exp = ref_res(o, a, b);
    bus.start = 1'b1;
    bus.op = o;
    bus.a_in = a;
    bus.b_in = b;
    bus.dest = d;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a_in = 16'($urandom);
    bus.b_in = 16'($urandom);
    bus.dest = 3'($urandom);
    bus.op = 2'($urandom);
    lat = 0;
    busy_ok = 1'b1;
    while (bus.done !== 1'b1 && lat < 40) begin
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), 16);
    check({tag, "_busy_run"}, 32'(busy_ok), 1);
    check({tag, "_busy_done"}, 32'(bus.busy), 1);
    check({tag, "_wben"}, 32'(bus.wbEnable), 1);
    check({tag, "_wbreg"}, 32'(bus.wbReg), 32'(d));
    check({tag, "_data"}, 32'(bus.wbData), 32'(exp));
    check({tag, "_dz"}, 32'(bus.divZero), 32'(o[1] && b == 16'h0));
    @(posedge clk);
    #1;
    check_idle({tag, "_after"});
  endtask

  initial begin
    int wb0;
    int lat;
    bit busy_ok;
    bus.start = 1'b0;
    bus.op = 2'd0;
    bus.a_in = '0;
    bus.b_in = '0;
    bus.dest = '0;

    #12;
    check_idle("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    run_op("mull_a", 2'd0, 16'h1234, 16'h0010, 3'd2);
    run_op("mulh_a", 2'd1, 16'h1234, 16'h0010, 3'd2);
    run_op("mulh_ff", 2'd1, 16'hFFFF, 16'hFFFF, 3'd5);
    run_op("mull_ff", 2'd0, 16'hFFFF, 16'hFFFF, 3'd6);
    run_op("div_100_7", 2'd2, 16'd100, 16'd7, 3'd1);
    run_op("mod_100_7", 2'd3, 16'd100, 16'd7, 3'd7);
    run_op("div_5_9", 2'd2, 16'h0005, 16'h0009, 3'd3);
    run_op("mod_5_9", 2'd3, 16'h0005, 16'h0009, 3'd4);
    run_op("div_z", 2'd2, 16'h1234, 16'h0000, 3'd2);
    run_op("mod_z", 2'd3, 16'h1234, 16'h0000, 3'd3);

    // Extra starts mid-RUN and during DONE, inputs changed mid-RUN.
    wb0 = wb_count;
    bus.start = 1'b1;
    bus.op = 2'd2;
    bus.a_in = 16'd1000;
    bus.b_in = 16'd33;
    bus.dest = 3'd6;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    lat = 0;
    busy_ok = 1'b1;
    while (bus.done !== 1'b1 && lat < 40) begin
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      bus.start = (lat == 5);
      if (lat == 7) begin
        bus.a_in = 16'hBEEF;
        bus.b_in = 16'h0003;
        bus.op = 2'd0;
        bus.dest = 3'd1;
      end
      @(posedge clk);
      #1;
      lat++;
    end
    check("ign_lat", 32'(lat), 16);
    check("ign_busy", 32'(busy_ok), 1);
    check("ign_data", 32'(bus.wbData), 32'(16'd1000 / 16'd33));
    check("ign_reg", 32'(bus.wbReg), 6);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check("ign_busy_after", 32'(bus.busy), 0);
    repeat (20) @(posedge clk);
    #1;
    check("ign_busy_late", 32'(bus.busy), 0);
    check("ign_wb_once", 32'(wb_count - wb0), 1);

    // Asynchronous reset mid-RUN discards the op.
    wb0 = wb_count;
    bus.start = 1'b1;
    bus.op = 2'd0;
    bus.a_in = 16'd77;
    bus.b_in = 16'd88;
    bus.dest = 3'd5;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (8) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_idle("arst");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (25) @(posedge clk);
    #1;
    check("arst_no_wb", 32'(wb_count - wb0), 0);
    run_op("post_rst", 2'd0, 16'd3, 16'd4, 3'd2);

    // Random ops against the reference model.
    for (int i = 0; i < 24; i++) begin
      logic [1:0] o;
      logic [15:0] a;
      logic [15:0] b;
      o = 2'($urandom);
      a = 16'($urandom);
      case ($urandom_range(0, 3))
        0: b = 16'h0;
        1: b = 16'($urandom_range(1, 15));
        default: b = 16'($urandom);
      endcase
      run_op("rand", o, a, b, 3'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
